maxpool_seq_ctrl: RTL

// - Sequencer for a 2D max-pool stage: walks an HxWxC feature map held in an external memory, one word per cycle.
// - Issues a read per window element, reduces each POOLxPOOL window in a running comparator, writes one result per window.
// - Sits between the layer controller (start/done) and the shared feature-map RAMs; replaces bulk in-memory pooling with a streamed schedule.

---
 rtl/maxpool_seq_ctrl.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/maxpool_seq_ctrl.sv
// maxpool_seq_ctrl: streamed 2D max-pool sequencer.
// Walks each POOL_SIZE x POOL_SIZE window of an H_IN x W_IN x CH feature map.
// It issues one read per window element and reduces each window with a running
// signed comparator. It writes one result per window.
// Optional build macro: MAXPOOL_CTRL_RELU_EN clamps negative results to zero
// (fused ReLU). When it is not defined, the raw signed maximum is written.
module maxpool_seq_ctrl #(
  parameter int H_IN      = 32,
  parameter int W_IN      = 32,
  parameter int CH        = 28,
  parameter int POOL_SIZE = 2,
  parameter int ADDR_W    = 15,
  parameter int DATA_W    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     rd_en,
  input  logic                     rd_ready,
  output logic [ADDR_W-1:0]        rd_addr,
  input  logic signed [DATA_W-1:0] rd_data,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [DATA_W-1:0]        wr_data
);

  localparam int H_OUT = H_IN / POOL_SIZE;
  localparam int W_OUT = W_IN / POOL_SIZE;
  localparam int OH_W  = (H_OUT > 1) ? $clog2(H_OUT) : 1;
  localparam int OW_W  = (W_OUT > 1) ? $clog2(W_OUT) : 1;
  localparam int OC_W  = (CH > 1) ? $clog2(CH) : 1;
  localparam int P_W   = $clog2(POOL_SIZE);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t state_q, state_d;

  logic [OH_W-1:0] oh_q;
  logic [OW_W-1:0] ow_q;
  logic [OC_W-1:0] oc_q;
  logic [P_W-1:0]  ph_q, pw_q;

  logic                     rsp_vld_q, rsp_first_q, rsp_last_q;
  logic [ADDR_W-1:0]        rsp_waddr_q;
  logic signed [DATA_W-1:0] acc_q, win_max;
  logic [DATA_W-1:0]        result;
  logic                     wr_en_q;
  logic [ADDR_W-1:0]        wr_addr_q;
  logic [DATA_W-1:0]        wr_data_q;

  logic rd_fire, pw_last, ph_last, oc_last, ow_last, oh_last, last_read;

  assign rd_fire   = rd_en && rd_ready;
  assign pw_last   = (pw_q == P_W'(POOL_SIZE - 1));
  assign ph_last   = (ph_q == P_W'(POOL_SIZE - 1));
  assign oc_last   = (oc_q == OC_W'(CH - 1));
  assign ow_last   = (ow_q == OW_W'(W_OUT - 1));
  assign oh_last   = (oh_q == OH_W'(H_OUT - 1));
  assign last_read = rd_fire && pw_last && ph_last && oc_last && ow_last && oh_last;

  // Read address of the current window element: ((h*W_IN)+w)*CH+c.
  assign rd_addr = ADDR_W'((((int'(oh_q) * POOL_SIZE + int'(ph_q)) * W_IN)
                            + int'(ow_q) * POOL_SIZE + int'(pw_q)) * CH + int'(oc_q));

  // FSM state register.
  // NOTE: the reset is synchronous, so it is sampled inside the clocked block only.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and state-decoded outputs.
  // NOTE: every output gets a default first, so no path leaves a latch behind.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    rd_en   = 1'b0;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN: begin
        busy  = 1'b1;
        rd_en = 1'b1;
        if (last_read) state_d = S_DRAIN;
      end
      // Only the final window's write can still be outstanding here.
      S_DRAIN: begin
        busy = 1'b1;
        if (wr_en_q) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Loop counters oh, ow, oc, ph, pw (innermost last). They advance only on accepted reads.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n || state_q == S_IDLE) begin
      oh_q <= '0;
      ow_q <= '0;
      oc_q <= '0;
      ph_q <= '0;
      pw_q <= '0;
    end else if (rd_fire) begin
      if (!pw_last) pw_q <= pw_q + 1'b1;
      else begin
        pw_q <= '0;
        if (!ph_last) ph_q <= ph_q + 1'b1;
        else begin
          ph_q <= '0;
          if (!oc_last) oc_q <= oc_q + 1'b1;
          else begin
            oc_q <= '0;
            if (!ow_last) ow_q <= ow_q + 1'b1;
            else begin
              ow_q <= '0;
              oh_q <= oh_last ? '0 : oh_q + 1'b1;
            end
          end
        end
      end
    end
  end

  // Tag each accepted read so that its data, which arrives one cycle later, knows its window role.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_vld_q   <= 1'b0;
      rsp_first_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      rsp_waddr_q <= '0;
    end else begin
      rsp_vld_q   <= rd_fire;
      rsp_first_q <= (ph_q == '0) && (pw_q == '0);
      rsp_last_q  <= ph_last && pw_last;
      rsp_waddr_q <= ADDR_W'(((int'(oh_q) * W_OUT) + int'(ow_q)) * CH + int'(oc_q));
    end
  end

  // Running comparator. The first element loads; a later element replaces only if it is strictly
  // greater, so among equal values the first maximum is kept.
  always_comb begin
    win_max = acc_q;
    if (rsp_first_q || rd_data > acc_q) win_max = rd_data;
`ifdef MAXPOOL_CTRL_RELU_EN
    result = win_max[DATA_W-1] ? '0 : win_max;
`else
    result = win_max;
`endif
  end

  // Accumulator and result write port, registered one cycle after the window's last data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= rsp_vld_q && rsp_last_q;
      if (rsp_vld_q) acc_q <= win_max;
      if (rsp_vld_q && rsp_last_q) begin
        wr_addr_q <= rsp_waddr_q;
        wr_data_q <= result;
      end
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

endmodule
